// File: rtl/search_block_loader.sv
// search_block_loader: streams a byte block into blk_mem_gen_0 at a base address,
// optionally re-reads it and compares an 8-bit modular checksum before pulsing done.
module search_block_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [ADDR_W-1:0] length,
    input  logic              verify,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] bytesWritten
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;
    localparam logic [ADDR_W-1:0] ONE = 1;
    state_t state;
    logic [ADDR_W-1:0] base, len, cnt;
    logic vfy;
    logic [7:0] wr_sum, rd_sum;
    logic [1:0] rv;
    logic hs;
    assign in_ready = (state == WRITE) && (cnt < len);
    assign hs = in_valid && in_ready;
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state <= IDLE;
            base <= '0;
            len <= '0;
            cnt <= '0;
            vfy <= 1'b0;
            wr_sum <= '0;
            rd_sum <= '0;
            rv <= '0;
            ena <= 1'b0;
            wea <= 1'b0;
            addra <= '0;
            dina <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            bytesWritten <= '0;
        end else begin
            done <= 1'b0;
            ena <= 1'b0;
            wea <= 1'b0;
            rv <= {rv[0], 1'b0};
            // rv[1] marks the cycle in which douta belongs to an issued read
            if (rv[1]) rd_sum <= rd_sum + 8'(douta);
            case (state)
                IDLE: if (start) begin
                    base <= baseAddr;
                    len <= length;
                    vfy <= verify;
                    cnt <= '0;
                    wr_sum <= '0;
                    rd_sum <= '0;
                    error <= 1'b0;
                    bytesWritten <= '0;
                    busy <= 1'b1;
                    state <= (length == '0) ? DONE : WRITE;
                end
                WRITE: if (hs) begin
                    ena <= 1'b1;
                    wea <= 1'b1;
                    addra <= base + cnt;
                    dina <= in_data;
                    wr_sum <= wr_sum + 8'(in_data);
                    bytesWritten <= bytesWritten + ONE;
                    cnt <= cnt + ONE;
                    if (cnt == len - ONE) begin
                        state <= vfy ? READ : DONE;
                        if (vfy) cnt <= '0;
                    end
                end
                READ: begin
                    ena <= 1'b1;
                    addra <= base + cnt;
                    cnt <= cnt + ONE;
                    rv <= {rv[0], 1'b1};
                    if (cnt == len - ONE) state <= DRAIN;
                end
                DRAIN: if (!rv[0]) state <= DONE;
                DONE: begin
                    done <= 1'b1;
                    error <= vfy && (rd_sum != wr_sum);
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_search_block_loader.sv
// tb_search_block_loader: directed tests of the block loader against a BRAM model
// with one-cycle read latency and an optional read corruption at address 0x12.
module tb_search_block_loader;
    logic CLK100MHZ = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [7:0] baseAddr = 8'h00;
    logic [7:0] length = 8'h00;
    logic verify = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_valid = 1'b0;
    logic in_ready, ena, wea, busy, done, error;
    logic [7:0] addra, dina, douta, bytesWritten;

    search_block_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .CLK100MHZ(CLK100MHZ), .reset(reset), .start(start), .baseAddr(baseAddr),
        .length(length), .verify(verify), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta), .busy(busy), .done(done), .error(error),
        .bytesWritten(bytesWritten)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    logic [7:0] mem [0:255];
    bit corrupt = 0;
    always @(posedge CLK100MHZ) begin
        if (ena) begin
            if (wea) mem[addra] <= dina;
            douta <= (corrupt && addra == 8'h12) ? (mem[addra] ^ 8'h01) : mem[addra];
        end
    end

    int cyc = 0;
    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    int sc, done_cnt, done_cyc, ena_cnt, idx;
    bit got_done, done_err;
    logic [7:0] wa[$], wd[$], ra[$];
    int wc[$], rc[$];
    logic [7:0] sd [0:15];

    always @(negedge CLK100MHZ) begin
        if (ena && wea) begin
            wa.push_back(addra);
            wd.push_back(dina);
            wc.push_back(cyc - sc);
        end
        if (ena && !wea) begin
            ra.push_back(addra);
            rc.push_back(cyc - sc);
        end
        if (ena) ena_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc - sc;
            done_err = error;
            got_done = 1;
        end
    end

    task automatic clear_log();
        wa.delete(); wd.delete(); ra.delete(); wc.delete(); rc.delete();
        got_done = 0; done_cnt = 0; ena_cnt = 0; idx = 0; done_cyc = -1; done_err = 0;
    endtask

    task automatic run_load(input logic [7:0] b, input logic [7:0] l, input logic v,
                            input int n, input bit tog, input int restart);
        clear_log();
        baseAddr = b; length = l; verify = v;
        @(posedge CLK100MHZ); #1;
        start = 1'b1;
        sc = cyc;
        for (int k = 0; k < 300 && !got_done; k++) begin
            if (k == restart) begin
                start = 1'b1;
                baseAddr = 8'h80;
            end
            in_valid = (idx < n) && (!tog || (k % 2 == 1));
            in_data = (idx < n) ? sd[idx] : 8'h00;
            @(negedge CLK100MHZ);
            if (in_valid && in_ready) idx++;
            @(posedge CLK100MHZ); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        if (!got_done) begin
            failures++;
            $display("FAIL timeout: no done within 300 cycles");
        end
        checks++;
        repeat (3) @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic test_reset();
        @(negedge CLK100MHZ);
        checks++;
        if ({in_ready, ena, wea, busy, done, error} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctl: got %b want 000000", {in_ready, ena, wea, busy, done, error});
        end
        checks++;
        if ({addra, dina, bytesWritten} !== 24'h0) begin
            failures++;
            $display("FAIL reset_bus: got %h want 000000", {addra, dina, bytesWritten});
        end
    endtask

    task automatic test_basic();
        sd[0] = 8'hA1; sd[1] = 8'hB2; sd[2] = 8'hC3; sd[3] = 8'hD4; sd[4] = 8'hE5;
        run_load(8'h10, 8'd4, 1'b0, 5, 0, -1);
        checks++;
        if (wa.size() !== 4) begin failures++; $display("FAIL basic_nwr: got %0d want 4", wa.size()); end
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== 8'(8'h10 + i) || wd[i] !== sd[i] || wc[i] !== i + 2) begin
                failures++;
                $display("FAIL basic_wr%0d: got a=%h d=%h c=%0d want a=%h d=%h c=%0d",
                         i, wa[i], wd[i], wc[i], 8'(8'h10 + i), sd[i], i + 2);
            end
        end
        checks++;
        if (done_cyc !== 6 || done_cnt !== 1) begin
            failures++; $display("FAIL basic_done: got cyc=%0d n=%0d want cyc=6 n=1", done_cyc, done_cnt);
        end
        checks++;
        if (done_err !== 1'b0 || bytesWritten !== 8'd4) begin
            failures++; $display("FAIL basic_status: got err=%b bw=%0d want err=0 bw=4", done_err, bytesWritten);
        end
        checks++;
        if (idx !== 4 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_consumed: got idx=%0d busy=%b want idx=4 busy=0", idx, busy);
        end
        checks++;
        if (mem[8'h13] !== 8'hD4) begin
            failures++; $display("FAIL basic_mem: got %h want d4", mem[8'h13]);
        end
    endtask

    task automatic test_toggle();
        run_load(8'h10, 8'd4, 1'b0, 4, 1, -1);
        checks++;
        if (wa.size() !== 4) begin failures++; $display("FAIL tog_nwr: got %0d want 4", wa.size()); end
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== 8'(8'h10 + i) || wc[i] !== 2 * i + 2) begin
                failures++;
                $display("FAIL tog_wr%0d: got a=%h c=%0d want a=%h c=%0d", i, wa[i], wc[i], 8'(8'h10 + i), 2 * i + 2);
            end
        end
        checks++;
        if (done_cyc !== 9) begin failures++; $display("FAIL tog_done: got %0d want 9", done_cyc); end
    endtask

    task automatic test_wrap();
        sd[0] = 8'h11; sd[1] = 8'h22; sd[2] = 8'h33; sd[3] = 8'h44;
        run_load(8'hFE, 8'd4, 1'b0, 4, 0, -1);
        checks++;
        if (wa.size() !== 4) begin failures++; $display("FAIL wrap_nwr: got %0d want 4", wa.size()); end
        for (int i = 0; i < 4 && i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== 8'(8'hFE + i) || mem[8'(8'hFE + i)] !== sd[i]) begin
                failures++;
                $display("FAIL wrap_%0d: got a=%h m=%h want a=%h m=%h", i, wa[i], mem[8'(8'hFE + i)], 8'(8'hFE + i), sd[i]);
            end
        end
    endtask

    task automatic test_verify(input bit bad);
        for (int i = 0; i < 8; i++) sd[i] = 8'(8'h30 + 7 * i);
        corrupt = bad;
        run_load(8'h10, 8'd8, 1'b1, 8, 0, -1);
        corrupt = 0;
        checks++;
        if (wa.size() !== 8 || ra.size() !== 8) begin
            failures++; $display("FAIL ver_counts: got wr=%0d rd=%0d want 8 8", wa.size(), ra.size());
        end
        for (int i = 0; i < 8 && i < ra.size(); i++) begin
            checks++;
            if (ra[i] !== 8'(8'h10 + i) || rc[i] !== i + 10) begin
                failures++;
                $display("FAIL ver_rd%0d: got a=%h c=%0d want a=%h c=%0d", i, ra[i], rc[i], 8'(8'h10 + i), i + 10);
            end
        end
        checks++;
        if (done_cyc !== 20 || done_err !== bad) begin
            failures++; $display("FAIL ver_done: got cyc=%0d err=%b want cyc=20 err=%b", done_cyc, done_err, bad);
        end
        checks++;
        if (error !== bad) begin failures++; $display("FAIL ver_hold: got %b want %b", error, bad); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        baseAddr = 8'h30; length = 8'd4; verify = 1'b0;
        @(posedge CLK100MHZ); #1;
        start = 1'b1; sc = cyc; in_valid = 1'b1; in_data = 8'h55;
        @(posedge CLK100MHZ); #1; start = 1'b0;
        @(posedge CLK100MHZ); #1;
        @(posedge CLK100MHZ); #1; reset = 1'b1;
        @(posedge CLK100MHZ); #1; reset = 1'b0;
        @(negedge CLK100MHZ);
        checks++;
        if ({busy, wea, ena, done, in_ready} !== 5'b0) begin
            failures++; $display("FAIL rst_mid: got %b want 00000", {busy, wea, ena, done, in_ready});
        end
        in_valid = 1'b0;
        repeat (5) @(posedge CLK100MHZ);
        #1;
        checks++;
        if (done_cnt !== 0 || wa.size() !== 2) begin
            failures++; $display("FAIL rst_nodone: got done=%0d wr=%0d want 0 2", done_cnt, wa.size());
        end
    endtask

    task automatic test_back_to_back();
        sd[0] = 8'h01; sd[1] = 8'h02; sd[2] = 8'h03; sd[3] = 8'h04;
        run_load(8'h20, 8'd4, 1'b0, 4, 0, 2);
        checks++;
        if (done_cyc !== 6 || done_cnt !== 1 || wa.size() !== 4) begin
            failures++; $display("FAIL b2b_done: got cyc=%0d n=%0d wr=%0d want 6 1 4", done_cyc, done_cnt, wa.size());
        end
        checks++;
        if (wa.size() == 4 && wa[3] !== 8'h23) begin
            failures++; $display("FAIL b2b_addr: got %h want 23", wa[3]);
        end
    endtask

    task automatic test_len0();
        run_load(8'h40, 8'd0, 1'b1, 2, 0, -1);
        checks++;
        if (done_cyc !== 2 || ena_cnt !== 0 || idx !== 0) begin
            failures++; $display("FAIL len0: got cyc=%0d ena=%0d idx=%0d want 2 0 0", done_cyc, ena_cnt, idx);
        end
        checks++;
        if (done_err !== 1'b0 || bytesWritten !== 8'd0) begin
            failures++; $display("FAIL len0_status: got err=%b bw=%0d want 0 0", done_err, bytesWritten);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(posedge CLK100MHZ);
        #1;
        test_reset();
        reset = 1'b0;
        test_basic();
        test_toggle();
        test_wrap();
        test_verify(0);
        test_verify(1);
        test_len0();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
